conv2d_stream_engine: RTL and testbench

- Parametrised successor to the single-window convolver. Loads a KERNEL_SIZE x KERNEL_SIZE signed kernel from kernel SRAM, then sweeps it over an IMG_W x IMG_H signed image held in image SRAM.
- Produces every "valid" output pixel in raster order over a ready/valid result port.
- Post-processes each accumulator with an arithmetic right shift and optional saturation. Sits between the NPU's SRAM banks and the result writeback unit.

---
 rtl/conv2d_stream_engine.sv | 236 +++++++++++++++++++++++
 tb/tb_conv2d_stream_engine.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv2d_stream_engine.sv
`default_nettype none
// ============================================================================
// Module      : conv2d_stream_engine
// Description : Loads a KxK signed kernel from kernel SRAM, sweeps it over an
//               IMG_W x IMG_H signed image in image SRAM and streams every
//               valid-region output pixel in raster order over a ready/valid
//               port after shift and optional saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module conv2d_stream_engine #(
  parameter int KERNEL_SIZE       = 3,
  parameter int DATA_WIDTH        = 8,
  parameter int IMG_W             = 8,
  parameter int IMG_H             = 8,
  parameter int IMG_ADDR_WIDTH    = 6,
  parameter int KERNEL_ADDR_WIDTH = 6,
  parameter int ACC_WIDTH         = 20,
  parameter int OUT_SHIFT         = 0,
  parameter int SATURATE          = 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_start,
  output logic                         o_busy,
  output logic [IMG_ADDR_WIDTH-1:0]    o_img_addr,
  input  logic [DATA_WIDTH-1:0]        i_img_data,
  output logic [KERNEL_ADDR_WIDTH-1:0] o_kernel_addr,
  input  logic [DATA_WIDTH-1:0]        i_kernel_data,
  output logic                         o_res_valid,
  input  logic                         i_res_ready,
  output logic [DATA_WIDTH-1:0]        o_res_data,
  output logic [IMG_ADDR_WIDTH-1:0]    o_res_addr,
  output logic                         o_done
);

  localparam int C_OUT_W = IMG_W - KERNEL_SIZE + 1;
  localparam int C_OUT_H = IMG_H - KERNEL_SIZE + 1;
  localparam int C_TAPS  = KERNEL_SIZE * KERNEL_SIZE;
  localparam int C_CNT_W = $clog2(C_TAPS + 1);
  localparam int C_X_W   = $clog2(C_OUT_W + 1);
  localparam int C_Y_W   = $clog2(C_OUT_H + 1);
  localparam int C_K_W   = $clog2(KERNEL_SIZE + 1);

  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(C_TAPS);
  localparam logic [C_CNT_W-1:0] C_CNT_PRE  = C_CNT_W'(C_TAPS - 1);
  localparam logic [C_K_W-1:0]   C_K_LAST   = C_K_W'(KERNEL_SIZE - 1);
  localparam logic [C_X_W-1:0]   C_X_LAST   = C_X_W'(C_OUT_W - 1);
  localparam logic [C_Y_W-1:0]   C_Y_LAST   = C_Y_W'(C_OUT_H - 1);

  localparam logic signed [ACC_WIDTH-1:0] C_RES_MAX = ACC_WIDTH'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] C_RES_MIN = ~C_RES_MAX;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_LOAD_KERNEL = 3'd1,
    S_MAC         = 3'd2,
    S_OUTPUT      = 3'd3,
    S_DONE        = 3'd4
  } state_t;

  state_t                        r_state;
  logic [C_CNT_W-1:0]            r_cnt;
  logic [C_X_W-1:0]              r_x;
  logic [C_Y_W-1:0]              r_y;
  logic [C_K_W-1:0]              r_tr;
  logic [C_K_W-1:0]              r_tc;
  logic signed [ACC_WIDTH-1:0]   r_acc;
  logic signed [DATA_WIDTH-1:0]  r_kernel [C_TAPS];

  logic [C_CNT_W-1:0]             w_kidx;
  logic signed [2*DATA_WIDTH-1:0] w_prod;
  logic signed [ACC_WIDTH-1:0]    w_acc_sum;
  logic signed [ACC_WIDTH-1:0]    w_shifted;
  logic [DATA_WIDTH-1:0]          w_post;
  logic [C_K_W-1:0]               w_tr_nxt;
  logic [C_K_W-1:0]               w_tc_nxt;
  logic [IMG_ADDR_WIDTH-1:0]      w_tap_addr;
  logic [IMG_ADDR_WIDTH-1:0]      w_base_nxt;
  logic [IMG_ADDR_WIDTH-1:0]      w_res_addr;
  logic                           w_last_x;
  logic                           w_last_pos;
  logic [C_X_W-1:0]               w_x_nxt;
  logic [C_Y_W-1:0]               w_y_nxt;

  // Linear image address of pixel (row, col).
  function automatic logic [IMG_ADDR_WIDTH-1:0] f_pix_addr(input logic [31:0] row,
                                                          input logic [31:0] col);
    return IMG_ADDR_WIDTH'(row * IMG_W + col);
  endfunction

  // Data returned this cycle belongs to the address issued on the previous
  // count, so both the kernel capture and the MAC use index cnt-1.
  assign w_kidx    = (r_cnt == '0) ? '0 : r_cnt - 1'b1;
  assign w_prod    = $signed(i_img_data) * r_kernel[w_kidx];
  assign w_acc_sum = r_acc + {{(ACC_WIDTH - 2*DATA_WIDTH){w_prod[2*DATA_WIDTH-1]}}, w_prod};

  // Tap walk in row-major order across the kernel window.
  assign w_tc_nxt   = (r_tc == C_K_LAST) ? '0 : r_tc + 1'b1;
  assign w_tr_nxt   = (r_tc == C_K_LAST) ? r_tr + 1'b1 : r_tr;
  assign w_tap_addr = f_pix_addr(32'(r_y) + 32'(w_tr_nxt), 32'(r_x) + 32'(w_tc_nxt));

  // Output-position raster walk.
  assign w_last_x   = (r_x == C_X_LAST);
  assign w_last_pos = w_last_x && (r_y == C_Y_LAST);
  assign w_x_nxt    = w_last_x ? '0 : r_x + 1'b1;
  assign w_y_nxt    = w_last_x ? r_y + 1'b1 : r_y;
  assign w_base_nxt = f_pix_addr(32'(w_y_nxt), 32'(w_x_nxt));
  assign w_res_addr = IMG_ADDR_WIDTH'(32'(r_y) * C_OUT_W + 32'(r_x));

  assign w_shifted = r_acc >>> OUT_SHIFT;

  generate
    if (SATURATE != 0) begin : g_sat
      // Clamp the shifted accumulator to the signed result range.
      always_comb begin
        w_post = w_shifted[DATA_WIDTH-1:0];
        if (w_shifted > C_RES_MAX) begin
          w_post = C_RES_MAX[DATA_WIDTH-1:0];
        end else if (w_shifted < C_RES_MIN) begin
          w_post = C_RES_MIN[DATA_WIDTH-1:0];
        end
      end
    end else begin : g_trunc
      assign w_post = w_shifted[DATA_WIDTH-1:0];
    end
  endgenerate

  // Control FSM with registered SRAM addresses, result port and status.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_x           <= '0;
      r_y           <= '0;
      r_tr          <= '0;
      r_tc          <= '0;
      r_acc         <= '0;
      o_busy        <= 1'b0;
      o_img_addr    <= '0;
      o_kernel_addr <= '0;
      o_res_valid   <= 1'b0;
      o_res_data    <= '0;
      o_res_addr    <= '0;
      o_done        <= 1'b0;
      for (int i = 0; i < C_TAPS; i++) begin
        r_kernel[i] <= '0;
      end
    end else begin
      o_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state       <= S_LOAD_KERNEL;
            o_busy        <= 1'b1;
            r_cnt         <= '0;
            r_x           <= '0;
            r_y           <= '0;
            o_kernel_addr <= '0;
          end
        end

        S_LOAD_KERNEL: begin
          if (r_cnt != '0) begin
            r_kernel[w_kidx] <= i_kernel_data;
          end
          if (r_cnt == C_CNT_LAST) begin
            r_state    <= S_MAC;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_tr       <= '0;
            r_tc       <= '0;
            o_img_addr <= f_pix_addr(32'(r_y), 32'(r_x));
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt != C_CNT_PRE) begin
              o_kernel_addr <= KERNEL_ADDR_WIDTH'(r_cnt + 1'b1);
            end
          end
        end

        S_MAC: begin
          if (r_cnt != '0) begin
            r_acc <= w_acc_sum;
          end
          if (r_cnt == C_CNT_LAST) begin
            r_state <= S_OUTPUT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt != C_CNT_PRE) begin
              r_tr       <= w_tr_nxt;
              r_tc       <= w_tc_nxt;
              o_img_addr <= w_tap_addr;
            end
          end
        end

        S_OUTPUT: begin
          // First cycle registers the post-processed result; it then holds
          // until the consumer accepts it.
          if (!o_res_valid) begin
            o_res_valid <= 1'b1;
            o_res_data  <= w_post;
            o_res_addr  <= w_res_addr;
          end else if (i_res_ready) begin
            o_res_valid <= 1'b0;
            if (w_last_pos) begin
              r_state <= S_DONE;
              o_done  <= 1'b1;
            end else begin
              r_state    <= S_MAC;
              r_x        <= w_x_nxt;
              r_y        <= w_y_nxt;
              r_cnt      <= '0;
              r_acc      <= '0;
              r_tr       <= '0;
              r_tc       <= '0;
              o_img_addr <= w_base_nxt;
            end
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          o_busy  <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv2d_stream_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv2d_stream_engine
// Description : Self-checking bench for conv2d_stream_engine. Three instances
//               (saturate/no-shift, truncate/shift-2, truncate/no-shift) share
//               stimulus and are compared against a direct convolution model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv2d_stream_engine;

  localparam int N_DUT  = 3;
  localparam int N_RES  = 36;
  localparam int GAP    = 11;
  localparam int FIRST  = 21;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic ready;
  logic clr;

  logic       busy      [N_DUT];
  logic       res_valid [N_DUT];
  logic       done      [N_DUT];
  logic [5:0] img_addr  [N_DUT];
  logic [5:0] ker_addr  [N_DUT];
  logic [5:0] res_addr  [N_DUT];
  logic [7:0] img_q     [N_DUT];
  logic [7:0] ker_q     [N_DUT];
  logic [7:0] res_data  [N_DUT];

  logic signed [7:0] img_mem [64];
  logic signed [7:0] ker_mem [64];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int hs_cnt   [N_DUT];
  int done_cnt [N_DUT];
  int hs_edge  [N_DUT];
  bit prev_valid [N_DUT];
  int stall_cyc;
  int ready_mode;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Direct convolution of the current memories for output index idx.
  function automatic int golden(int g, int idx);
    int y, x, s;
    y = idx / 6;
    x = idx % 6;
    s = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        s += int'(img_mem[(y + r) * 8 + x + c]) * int'(ker_mem[r * 3 + c]);
    s = s >>> ((g == 1) ? 2 : 0);
    if (g == 0) begin
      if (s > 127) s = 127;
      else if (s < -128) s = -128;
    end else begin
      s = int'(byte'(s));
    end
    return s;
  endfunction

  generate
    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
      conv2d_stream_engine #(
        .OUT_SHIFT((g == 1) ? 2 : 0),
        .SATURATE ((g == 0) ? 1 : 0)
      ) u_dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (start),
        .o_busy        (busy[g]),
        .o_img_addr    (img_addr[g]),
        .i_img_data    (img_q[g]),
        .o_kernel_addr (ker_addr[g]),
        .i_kernel_data (ker_q[g]),
        .o_res_valid   (res_valid[g]),
        .i_res_ready   (ready),
        .o_res_data    (res_data[g]),
        .o_res_addr    (res_addr[g]),
        .o_done        (done[g])
      );
    end
  endgenerate

  // Synchronous-read SRAM models, one read port per instance.
  always @(posedge clk) begin
    for (int g = 0; g < N_DUT; g++) begin
      img_q[g] <= img_mem[img_addr[g]];
      ker_q[g] <= ker_mem[ker_addr[g]];
    end
  end

  // Result monitor / scoreboard, sampling on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n || clr) begin
        for (int g = 0; g < N_DUT; g++) begin
          hs_cnt[g] = 0; done_cnt[g] = 0; hs_edge[g] = 0; prev_valid[g] = 1'b0;
        end
        stall_cyc = 0;
      end else begin
        for (int g = 0; g < N_DUT; g++) begin
          if (res_valid[g]) begin
            if (!prev_valid[g] && hs_cnt[g] > 0)
              chk($sformatf("result_gap_d%0d", g), cyc - hs_edge[g], GAP);
            if (hs_cnt[g] >= N_RES) begin
              chk($sformatf("extra_result_d%0d", g), hs_cnt[g], N_RES - 1);
            end else begin
              chk($sformatf("res_data_d%0d_i%0d", g, hs_cnt[g]),
                  int'($signed(res_data[g])), golden(g, hs_cnt[g]));
              chk($sformatf("res_addr_d%0d", g), int'(res_addr[g]), hs_cnt[g]);
            end
            if (ready) begin
              hs_cnt[g]++;
              hs_edge[g] = cyc + 1;
            end else if (g == 0) begin
              stall_cyc++;
            end
          end
          if (done[g]) begin
            done_cnt[g]++;
            chk($sformatf("done_after_all_d%0d", g), hs_cnt[g], N_RES);
          end
          prev_valid[g] = res_valid[g];
        end
      end
    end
  end

  // Ready driver: 0 = always ready, 1 = random, 2 = 5-cycle stall on result 3.
  initial begin
    int stall_left;
    bit stall_done;
    ready = 1'b1;
    stall_left = 0;
    stall_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (hs_cnt[0] == 0) stall_done = 1'b0;
      if (stall_left > 0) begin
        ready = 1'b0;
        stall_left--;
      end else if (ready_mode == 2 && !stall_done && res_valid[0] && hs_cnt[0] == 3) begin
        ready = 1'b0;
        stall_left = 4;
        stall_done = 1'b1;
      end else if (ready_mode == 1) begin
        ready = ($urandom_range(0, 3) != 0);
      end else begin
        ready = 1'b1;
      end
    end
  end

  task automatic load_pattern(input int kind);
    for (int i = 0; i < 64; i++) begin
      ker_mem[i] = 8'sd0;
      case (kind)
        0: img_mem[i] = 8'(i);
        1: img_mem[i] = 8'sd1;
        2: img_mem[i] = 8'sd127;
        3: img_mem[i] = -8'sd128;
        default: img_mem[i] = 8'($urandom);
      endcase
    end
    for (int i = 0; i < 9; i++) begin
      case (kind)
        0: ker_mem[i] = (i == 4) ? 8'sd1 : 8'sd0;
        1: ker_mem[i] = 8'sd1;
        2, 3: ker_mem[i] = 8'sd127;
        default: ker_mem[i] = 8'($urandom);
      endcase
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int g = 0; g < N_DUT; g++) begin
      chk($sformatf("%s_busy_d%0d", tag, g), int'(busy[g]), 0);
      chk($sformatf("%s_valid_d%0d", tag, g), int'(res_valid[g]), 0);
      chk($sformatf("%s_done_d%0d", tag, g), int'(done[g]), 0);
      chk($sformatf("%s_img_addr_d%0d", tag, g), int'(img_addr[g]), 0);
      chk($sformatf("%s_ker_addr_d%0d", tag, g), int'(ker_addr[g]), 0);
      chk($sformatf("%s_res_data_d%0d", tag, g), int'(res_data[g]), 0);
      chk($sformatf("%s_res_addr_d%0d", tag, g), int'(res_addr[g]), 0);
    end
  endtask

  task automatic run_job(input int mode, input bit lat, input bit dbl, input bit abort);
    int n;
    bit fin;
    bit aborted;
    clr = 1'b1;
    @(negedge clk);
    #1 clr = 1'b0;
    ready_mode = mode;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    if (lat) begin
      n = 0;
      while (n < 100 && !res_valid[0]) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk("first_valid_latency", n, FIRST);
    end
    fin = 1'b0;
    aborted = 1'b0;
    for (int c = 0; c < 4000 && !fin && !aborted; c++) begin
      @(posedge clk);
      #1;
      start = (dbl && c == 40);
      if (abort && hs_cnt[0] == 10) begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("abort_hold");
        rst_n = 1'b1;
        aborted = 1'b1;
      end
      if (done_cnt[0] > 0) fin = 1'b1;
    end
    start = 1'b0;
    if (abort) begin
      chk("abort_reached", int'(aborted), 1);
    end else begin
      chk("job_finished", int'(fin), 1);
      repeat (3) @(posedge clk);
      #1;
      for (int g = 0; g < N_DUT; g++) begin
        chk($sformatf("done_pulses_d%0d", g), done_cnt[g], 1);
        chk($sformatf("handshakes_d%0d", g), hs_cnt[g], N_RES);
        chk($sformatf("idle_busy_d%0d", g), int'(busy[g]), 0);
      end
      if (mode == 2) chk("stall_cycles", stall_cyc, 5);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    clr = 1'b0;
    ready_mode = 0;
    load_pattern(0);
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    load_pattern(0); run_job(0, 1'b1, 1'b0, 1'b0);   // identity kernel, latency
    load_pattern(1); run_job(2, 1'b0, 1'b0, 1'b0);   // all ones, stall on result 3
    load_pattern(2); run_job(1, 1'b0, 1'b1, 1'b0);   // positive saturation, stray start
    load_pattern(3); run_job(0, 1'b1, 1'b0, 1'b0);   // negative saturation
    load_pattern(4); run_job(1, 1'b0, 1'b0, 1'b1);   // reset mid-MAC
    load_pattern(4); run_job(1, 1'b0, 1'b0, 1'b0);   // full run after abort
    load_pattern(4); run_job(0, 1'b0, 1'b1, 1'b0);   // random data, stray start

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
